// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, sync polarities and the coordinate type.
package vga_pkg;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Both syncs are active-low for this mode.
   localparam logic HS_ACTIVE = 1'b0;
   localparam logic VS_ACTIVE = 1'b0;

   localparam int unsigned COORD_W    = 10;
   localparam int unsigned COORD_SPAN = 1 << COORD_W;

   typedef logic [COORD_W-1:0] coord_t;

   function automatic coord_t to_coord(input int unsigned v);
      return coord_t'(v);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..LIMIT while enabled, wraps to 0 and flags the wrap.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter coord_t LIMIT = to_coord(H_TOTAL - 1)
) (
   input  logic   clk_i,
   input  logic   reset_i,
   input  logic   en_i,
   output coord_t count_o,
   output logic   wrap_o
);

   coord_t count_q, count_d;

   // Wrap is an explicit compare against the limit, never a natural overflow.
   assign wrap_o  = en_i && (count_q == LIMIT);
   assign count_o = count_q;

   // Next count: hold, increment, or return to zero at the limit.
   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = wrap_o ? '0 : count_q + coord_t'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) count_q <= '0;
      else         count_q <= count_d;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus registered decode of
// sync, display-enable, position and start-of-line/frame pulses.
// Optional feature macro: VGA_FRAME_COUNT_EN (frame counter on frame_count).
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned P_H_VISIBLE = H_VISIBLE,
   parameter int unsigned P_H_FRONT   = H_FRONT,
   parameter int unsigned P_H_SYNC    = H_SYNC,
   parameter int unsigned P_H_BACK    = H_BACK,
   parameter int unsigned P_V_VISIBLE = V_VISIBLE,
   parameter int unsigned P_V_FRONT   = V_FRONT,
   parameter int unsigned P_V_SYNC    = V_SYNC,
   parameter int unsigned P_V_BACK    = V_BACK
) (
   input  logic        vga_clk,
   input  logic        reset,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        sync,
   output coord_t      DrawX,
   output coord_t      DrawY,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int unsigned LINE_TOTAL  = P_H_VISIBLE + P_H_FRONT + P_H_SYNC + P_H_BACK;
   localparam int unsigned FRAME_TOTAL = P_V_VISIBLE + P_V_FRONT + P_V_SYNC + P_V_BACK;

   localparam coord_t H_LIMIT      = to_coord(LINE_TOTAL - 1);
   localparam coord_t V_LIMIT      = to_coord(FRAME_TOTAL - 1);
   localparam coord_t H_VIS_END    = to_coord(P_H_VISIBLE);
   localparam coord_t V_VIS_END    = to_coord(P_V_VISIBLE);
   localparam coord_t H_SYNC_START = to_coord(P_H_VISIBLE + P_H_FRONT);
   localparam coord_t H_SYNC_END   = to_coord(P_H_VISIBLE + P_H_FRONT + P_H_SYNC);
   localparam coord_t V_SYNC_START = to_coord(P_V_VISIBLE + P_V_FRONT);
   localparam coord_t V_SYNC_END   = to_coord(P_V_VISIBLE + P_V_FRONT + P_V_SYNC);

   // Coordinates are 10 bits wide, so neither axis may exceed 1024 counts.
   if (LINE_TOTAL > COORD_SPAN) begin : g_line_too_long
      $error("vga_timing_gen: line total exceeds 10-bit coordinate range");
   end
   if (FRAME_TOTAL > COORD_SPAN) begin : g_frame_too_long
      $error("vga_timing_gen: frame total exceeds 10-bit coordinate range");
   end

   coord_t hc, vc;
   logic   h_wrap;
   logic   v_wrap_unused;

   vga_axis_counter #(.LIMIT(H_LIMIT)) u_hcnt (
      .clk_i   (vga_clk),
      .reset_i (reset),
      .en_i    (1'b1),
      .count_o (hc),
      .wrap_o  (h_wrap)
   );

   // Vertical axis advances only when the line wraps, so it wraps with hc.
   vga_axis_counter #(.LIMIT(V_LIMIT)) u_vcnt (
      .clk_i   (vga_clk),
      .reset_i (reset),
      .en_i    (h_wrap),
      .count_o (vc),
      .wrap_o  (v_wrap_unused)
   );

   coord_t draw_x_q, draw_x_d;
   coord_t draw_y_q, draw_y_d;
   logic   hs_q, hs_d;
   logic   vs_q, vs_d;
   logic   blank_q, blank_d;
   logic   line_start_q, line_start_d;
   logic   frame_start_q, frame_start_d;

   // Decode the current (hc,vc) into the values shown on the next cycle.
   always_comb begin
      draw_x_d      = hc;
      draw_y_d      = vc;
      hs_d          = ((hc >= H_SYNC_START) && (hc < H_SYNC_END)) ? HS_ACTIVE : ~HS_ACTIVE;
      vs_d          = ((vc >= V_SYNC_START) && (vc < V_SYNC_END)) ? VS_ACTIVE : ~VS_ACTIVE;
      blank_d       = (hc < H_VIS_END) && (vc < V_VIS_END);
      line_start_d  = (hc == '0);
      frame_start_d = (hc == '0) && (vc == '0);
   end

   // Output registers; reset forces syncs inactive at once, cutting any pulse short.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         draw_x_q      <= '0;
         draw_y_q      <= '0;
         hs_q          <= ~HS_ACTIVE;
         vs_q          <= ~VS_ACTIVE;
         blank_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         draw_x_q      <= draw_x_d;
         draw_y_q      <= draw_y_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_q       <= blank_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign DrawX       = draw_x_q;
   assign DrawY       = draw_y_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank       = blank_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign sync        = 1'b0;

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_cnt_q;

   // Bump the frame counter the cycle after each frame_start; wraps naturally at 16 bits.
   always_ff @(posedge vga_clk) begin
      if (reset)              frame_cnt_q <= '0;
      else if (frame_start_q) frame_cnt_q <= frame_cnt_q + 16'd1;
   end

   assign frame_count = frame_cnt_q;
`else
   assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen (640x480, 800x525 totals).
module tb_vga_timing_gen;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic        hs, vs, blank, sync, line_start, frame_start;
   logic [9:0]  DrawX, DrawY;
   logic [15:0] frame_count;

   int checks = 0;
   int passed = 0;

   vga_timing_gen dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .hs          (hs),
      .vs          (vs),
      .blank       (blank),
      .sync        (sync),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .line_start  (line_start),
      .frame_start (frame_start),
      .frame_count (frame_count)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge vga_clk);
      checks++; if ({DrawX, DrawY} !== 20'd0) $display("FAIL reset_pos: got x=%0d y=%0d, want 0,0", DrawX, DrawY); else passed++;
      checks++; if ({hs, vs} !== 2'b11) $display("FAIL reset_sync: got hs=%b vs=%b, want 1,1", hs, vs); else passed++;
      checks++; if (blank !== 1'b0) $display("FAIL reset_blank: got %b, want 0", blank); else passed++;
      checks++; if ({line_start, frame_start} !== 2'b00) $display("FAIL reset_pulses: got ls=%b fs=%b, want 0,0", line_start, frame_start); else passed++;
      checks++; if (frame_count !== 16'h0000) $display("FAIL reset_fcount: got %h, want 0000", frame_count); else passed++;
      checks++; if (sync !== 1'b0) $display("FAIL sync_tied: got %b, want 0", sync); else passed++;
      reset = 1'b0;
      @(negedge vga_clk);
      checks++; if ({DrawX, DrawY} !== 20'd0) $display("FAIL first_pos: got x=%0d y=%0d, want 0,0", DrawX, DrawY); else passed++;
      checks++; if ({blank, line_start, frame_start} !== 3'b111) $display("FAIL first_flags: got blank=%b ls=%b fs=%b, want 1,1,1", blank, line_start, frame_start); else passed++;
   endtask

   // Starts on pixel (0,0); leaves the bench on pixel (0,1).
   task automatic test_line();
      int hs_low = 0, hs_first = -1, hs_last = -1;
      int bl_cnt = 0, bl_first = -1, bl_last = -1;
      int xerr = 0;
      for (int i = 0; i < 800; i++) begin
         if (DrawX !== 10'(i) || DrawY !== 10'd0) xerr++;
         if (hs === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = i; hs_last = i; end
         if (blank === 1'b1) begin bl_cnt++; if (bl_first < 0) bl_first = i; bl_last = i; end
         @(negedge vga_clk);
      end
      checks++; if (xerr != 0) $display("FAIL line_drawx: %0d bad samples, want 0", xerr); else passed++;
      checks++; if (hs_low != 96) $display("FAIL hs_width: got %0d, want 96", hs_low); else passed++;
      checks++; if (hs_first != 656 || hs_last != 751) $display("FAIL hs_span: got %0d..%0d, want 656..751", hs_first, hs_last); else passed++;
      checks++; if (bl_cnt != 640) $display("FAIL blank_width: got %0d, want 640", bl_cnt); else passed++;
      checks++; if (bl_first != 0 || bl_last != 639) $display("FAIL blank_span: got %0d..%0d, want 0..639", bl_first, bl_last); else passed++;
   endtask

   // Runs the rest of frame 0 against a position model; ends on (0,0) of frame 1.
   task automatic test_frame();
      int ex = 0, ey = 1;
      int mism = 0, first_bad = -1;
      int vs_low = 0, vs_first = -1, vs_last = -1;
      int bl_bad = 0, period = -1;
      logic ehs, evs, ebl, els, efs;
      for (int cyc = 800; cyc <= 420000; cyc++) begin
         ehs = !(ex >= 656 && ex < 752);
         evs = !(ey >= 490 && ey < 492);
         ebl = (ex < 640) && (ey < 480);
         els = (ex == 0);
         efs = (ex == 0) && (ey == 0);
         if (DrawX !== 10'(ex) || DrawY !== 10'(ey) || hs !== ehs || vs !== evs ||
             blank !== ebl || line_start !== els || frame_start !== efs) begin
            mism++;
            if (first_bad < 0) first_bad = cyc;
         end
         if (vs === 1'b0) begin vs_low++; if (vs_first < 0) vs_first = int'(DrawY); vs_last = int'(DrawY); end
         if (DrawY >= 10'd480 && blank === 1'b1) bl_bad++;
         if (frame_start === 1'b1 && period < 0) period = cyc;
         if (ex == 799 && ey == 10) begin
            checks++; if ({DrawX, DrawY} !== {10'd799, 10'd10}) $display("FAIL pre_line11: got %0d,%0d, want 799,10", DrawX, DrawY); else passed++;
         end
         if (ex == 0 && ey == 11) begin
            checks++; if ({DrawX, DrawY} !== {10'd0, 10'd11} || line_start !== 1'b1) $display("FAIL line11_start: got %0d,%0d ls=%b, want 0,11 ls=1", DrawX, DrawY, line_start); else passed++;
         end
         if (ex == 799 && ey == 524) begin
            checks++; if ({DrawX, DrawY} !== {10'd799, 10'd524}) $display("FAIL frame_last: got %0d,%0d, want 799,524", DrawX, DrawY); else passed++;
         end
         if (cyc == 420000) begin
            checks++; if ({DrawX, DrawY} !== 20'd0 || frame_start !== 1'b1) $display("FAIL frame_wrap: got %0d,%0d fs=%b, want 0,0 fs=1", DrawX, DrawY, frame_start); else passed++;
         end else begin
            ex++;
            if (ex == 800) begin ex = 0; ey++; if (ey == 525) ey = 0; end
            @(negedge vga_clk);
         end
      end
      checks++; if (mism != 0) $display("FAIL frame_model: %0d bad samples, first at cycle %0d, want 0", mism, first_bad); else passed++;
      checks++; if (period != 420000) $display("FAIL frame_period: got %0d, want 420000", period); else passed++;
      checks++; if (vs_low != 1600) $display("FAIL vs_width: got %0d cycles, want 1600", vs_low); else passed++;
      checks++; if (vs_first != 490 || vs_last != 491) $display("FAIL vs_span: got lines %0d..%0d, want 490..491", vs_first, vs_last); else passed++;
      checks++; if (bl_bad != 0) $display("FAIL blank_vert: %0d samples with blank=1 at DrawY>=480, want 0", bl_bad); else passed++;
   endtask

   // Starts on (0,0); resets at (700,300) while hs is low, then checks recovery.
   task automatic test_mid_reset();
      int bad = 0;
      repeat (300 * 800 + 700) @(negedge vga_clk);
      checks++; if ({DrawX, DrawY} !== {10'd700, 10'd300} || hs !== 1'b0) $display("FAIL mid_pos: got %0d,%0d hs=%b, want 700,300 hs=0", DrawX, DrawY, hs); else passed++;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge vga_clk);
         if (hs !== 1'b1 || vs !== 1'b1 || blank !== 1'b0 || DrawX !== 10'd0 || DrawY !== 10'd0 ||
             line_start !== 1'b0 || frame_start !== 1'b0) bad++;
      end
      checks++; if (bad != 0) $display("FAIL mid_reset_hold: %0d bad reset cycles, want 0", bad); else passed++;
      reset = 1'b0;
      @(negedge vga_clk);
      checks++; if ({DrawX, DrawY} !== 20'd0 || frame_start !== 1'b1 || blank !== 1'b1) $display("FAIL mid_reset_exit: got %0d,%0d fs=%b blank=%b, want 0,0 1 1", DrawX, DrawY, frame_start, blank); else passed++;
      @(negedge vga_clk);
      checks++; if (DrawX !== 10'd1 || frame_start !== 1'b0 || line_start !== 1'b0) $display("FAIL mid_reset_next: got x=%0d fs=%b ls=%b, want 1 0 0", DrawX, frame_start, line_start); else passed++;
   endtask

   // Starts one cycle after a post-reset frame_start.
   task automatic test_frame_count();
`ifdef VGA_FRAME_COUNT_EN
      int waited;
      checks++; if (frame_count !== 16'd1) $display("FAIL fcount_first: got %0d, want 1", frame_count); else passed++;
      for (int f = 0; f < 2; f++) begin
         waited = 0;
         while (frame_start !== 1'b1 && waited < 420010) begin @(negedge vga_clk); waited++; end
         @(negedge vga_clk);
      end
      checks++; if (frame_count !== 16'd3) $display("FAIL fcount_three: got %0d, want 3", frame_count); else passed++;
      force dut.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
      waited = 0;
      while (frame_start !== 1'b1 && waited < 420010) begin @(negedge vga_clk); waited++; end
      @(negedge vga_clk);
      checks++; if (frame_count !== 16'h0000) $display("FAIL fcount_wrap: got %h, want 0000", frame_count); else passed++;
`else
      checks++; if (frame_count !== 16'h0000) $display("FAIL fcount_off: got %h, want 0000", frame_count); else passed++;
`endif
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_line();
      test_frame();
      test_mid_reset();
      test_frame_count();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001: H_VISIBLE, 640, active pixels per line.
- REQ-002: H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixel clocks; line total 800.
- REQ-003: V_VISIBLE, 480, active lines per frame.
- REQ-004: V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines; frame total 525.
- REQ-005: vga_clk  input  1  pixel clock; one clock; all state updates on its rising edge.
- REQ-006: reset  input  1  synchronous, active-high reset.
- REQ-007: hs  output  1  horizontal sync, active-low.
- REQ-008: vs  output  1  vertical sync, active-low.
- REQ-009: blank  output  1  display-enable; 1 inside the visible 640x480 window, 0 elsewhere (downstream pixel stages gate RGB with it).
- REQ-010: sync  output  1  composite sync, tied 0.
- REQ-011: DrawX  output  10  current pixel column, 0..799.
- REQ-012: DrawY  output  10  current line, 0..524.
- REQ-013: line_start  output  1  one-cycle pulse when DrawX==0.
- REQ-014: frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0.
- REQ-015: frame_count  output  16  completed-frame counter (see Configuration).

Function
- REQ-016: Internal hc counts 0..799 and wraps to 0; vc increments only on hc wrap, counts 0..524, wraps to 0 when hc and vc wrap together.
- REQ-017: All outputs are registered; each is a one-cycle-delayed decode of (hc,vc), so DrawX, DrawY, hs, vs, blank, line_start and frame_start are mutually cycle-aligned.
- REQ-018: hs = 0 exactly for DrawX in 656..751, else 1.
- REQ-019: vs = 0 exactly for DrawY in 490..491, else 1.
- REQ-020: blank = 1 iff DrawX<640 and DrawY<480.
- REQ-021: Counter arithmetic is 10-bit unsigned; compare against wrap limits (799, 524), never rely on natural overflow.
- REQ-022: frame_count increments by 1 in the cycle after frame_start is high and wraps 0xFFFF->0x0000.
- REQ-023: Derived line and frame totals come from the parameters; DrawX/DrawY width stays 10 bits, so line total must not exceed 1024 (elaboration-time assertion).

Reset
- REQ-024: While reset=1: hc=vc=0, DrawX=DrawY=0, hs=vs=1, blank=0, line_start=frame_start=0, frame_count=0.
- REQ-025: First rising edge with reset=0: outputs show pixel (0,0): DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1; hc becomes 1.
- REQ-026: Reset asserted mid-frame takes effect at the next edge regardless of position; no partial sync pulse is extended.

Configuration
- REQ-027: Macro VGA_FRAME_COUNT_EN: when defined, frame_count is implemented per REQ-022.
- REQ-028: When VGA_FRAME_COUNT_EN is undefined, frame_count is tied to 16'h0000, no counter flops exist, and all other behaviour is unchanged.

Structure
- REQ-029: Timing defaults (640/16/96/48, 480/10/2/33), line total 800, frame total 525 and HS/VS polarity constants live in shared package vga_pkg, alongside the typedef coord_t (10-bit unsigned).
- REQ-030: One sub-module, vga_axis_counter (parameterised wrap limit, enable, wrap-pulse output), is instantiated twice: horizontal with enable=1, vertical with enable=horizontal wrap.

Verification
- REQ-031: Release reset, count cycles between successive frame_start pulses -> exactly 420000.
- REQ-032: Sample a full line -> hs low for 96 consecutive cycles starting at DrawX=656; blank high for 640 cycles starting at DrawX=0.
- REQ-033: Sample a full frame -> vs low for 2 lines (DrawY=490,491) = 1600 cycles; blank never high when DrawY>=480.
- REQ-034: Boundary check -> (DrawX,DrawY)=(799,524) is followed next cycle by (0,0) with frame_start=1; (799,10) is followed by (0,11) with line_start=1.
- REQ-035: Assert reset at DrawX=700, DrawY=300 for 3 cycles -> during reset hs=vs=1, blank=0; first post-reset cycle shows (0,0), frame_start=1.
- REQ-036: With VGA_FRAME_COUNT_EN, run 3 frames -> frame_count=3; force internal count to 0xFFFF, next frame -> 0x0000; without the macro, frame_count stays 0.
